// File: rtl/multi_variable_clock_if.sv
// Bus bundle for multi_variable_clock: half-period write port, run enables and
// the divided-clock/tick/pending outputs.
// Optional macro PHASE_ALIGN_EN adds the align strobe to the bundle.
interface multi_variable_clock_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [DIV_W-1:0]  wr_div;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] var_clock;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pend;
`ifdef PHASE_ALIGN_EN
  logic              align;
`endif

  modport master (
    output wr_en, wr_ch, wr_div, ch_en,
`ifdef PHASE_ALIGN_EN
    output align,
`endif
    input  var_clock, tick, pend
  );

  modport slave (
    input  wr_en, wr_ch, wr_div, ch_en,
`ifdef PHASE_ALIGN_EN
    input  align,
`endif
    output var_clock, tick, pend
  );
endinterface

// File: rtl/multi_variable_clock.sv
// N-channel programmable clock divider. Each channel emits a 50%-duty clock
// toggling every D+1 base cycles plus a one-cycle tick on its rising edge.
// A written half-period code waits in a pending register and is adopted only
// at the channel's next toggle boundary, so no runt pulses are produced.
// Optional macro PHASE_ALIGN_EN adds an align strobe that restarts every
// channel in phase.
module multi_variable_clock #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                   base_clock,
  input  logic                   rst_n,
  multi_variable_clock_if.slave  bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DIV_W-1:0] DEF_CODE = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0]  r_cnt     [NUM_CH];
  logic [DIV_W-1:0]  r_active  [NUM_CH];
  logic [DIV_W-1:0]  r_pending [NUM_CH];
  logic [NUM_CH-1:0] r_var_clock;
  logic [NUM_CH-1:0] r_tick;
  logic [NUM_CH-1:0] r_pend;

  logic [DIV_W-1:0]  w_cnt_nxt     [NUM_CH];
  logic [DIV_W-1:0]  w_active_nxt  [NUM_CH];
  logic [DIV_W-1:0]  w_pending_nxt [NUM_CH];
  logic [NUM_CH-1:0] w_var_nxt;
  logic [NUM_CH-1:0] w_tick_nxt;
  logic [NUM_CH-1:0] w_pend_nxt;
  logic [NUM_CH-1:0] w_hit;
  logic              w_align;

`ifdef PHASE_ALIGN_EN
  assign w_align = bus.align;
`else
  assign w_align = 1'b0;
`endif

  // Per-channel next state: align restart, boundary toggle/reload, count, or write capture
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_active_nxt  = r_active;
    w_pending_nxt = r_pending;
    w_var_nxt     = r_var_clock;
    w_pend_nxt    = r_pend;
    w_tick_nxt    = '0;
    w_hit         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // Channel indices at or above NUM_CH never match, so such writes fall away.
      w_hit[i] = bus.wr_en && (bus.wr_ch == CH_W'(i));
      if (w_align) begin
        w_cnt_nxt[i]    = '0;
        w_var_nxt[i]    = 1'b0;
        w_active_nxt[i] = r_pending[i];
        w_pend_nxt[i]   = w_hit[i];
        if (w_hit[i]) w_pending_nxt[i] = bus.wr_div;
      end else if (bus.ch_en[i] && (r_cnt[i] == r_active[i])) begin
        // A write landing on the boundary itself is adopted at once.
        w_cnt_nxt[i]     = '0;
        w_var_nxt[i]     = ~r_var_clock[i];
        w_tick_nxt[i]    = ~r_var_clock[i];
        w_active_nxt[i]  = w_hit[i] ? bus.wr_div : r_pending[i];
        w_pending_nxt[i] = w_hit[i] ? bus.wr_div : r_pending[i];
        w_pend_nxt[i]    = 1'b0;
      end else begin
        if (bus.ch_en[i]) w_cnt_nxt[i] = r_cnt[i] + DIV_W'(1);
        if (w_hit[i]) begin
          w_pending_nxt[i] = bus.wr_div;
          w_pend_nxt[i]    = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous reset to the default half-period
  always_ff @(posedge base_clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i]     <= '0;
        r_active[i]  <= DEF_CODE;
        r_pending[i] <= DEF_CODE;
      end
      r_var_clock <= '0;
      r_tick      <= '0;
      r_pend      <= '0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_active    <= w_active_nxt;
      r_pending   <= w_pending_nxt;
      r_var_clock <= w_var_nxt;
      r_tick      <= w_tick_nxt;
      r_pend      <= w_pend_nxt;
    end
  end

  assign bus.var_clock = r_var_clock;
  assign bus.tick      = r_tick;
  assign bus.pend      = r_pend;
endmodule

// File: tb/tb_multi_variable_clock.sv
// Bench for multi_variable_clock (NUM_CH=4, DIV_W=8, DEFAULT_DIV=2) plus a
// NUM_CH=3 instance sharing the write port to confirm out-of-range writes vanish.
module tb_multi_variable_clock;
  logic base_clock = 1'b0;
  logic rst_n      = 1'b0;

  multi_variable_clock_if #(.NUM_CH(4), .DIV_W(8)) bus ();
  multi_variable_clock_if #(.NUM_CH(3), .DIV_W(8)) bus3 ();

  multi_variable_clock #(.NUM_CH(4), .DIV_W(8), .DEFAULT_DIV(2)) dut (
    .base_clock(base_clock), .rst_n(rst_n), .bus(bus));
  multi_variable_clock #(.NUM_CH(3), .DIV_W(8), .DEFAULT_DIV(2)) dut3 (
    .base_clock(base_clock), .rst_n(rst_n), .bus(bus3));

  assign bus3.wr_en  = bus.wr_en;
  assign bus3.wr_ch  = bus.wr_ch;
  assign bus3.wr_div = bus.wr_div;
  assign bus3.ch_en  = bus.ch_en[2:0];
`ifdef PHASE_ALIGN_EN
  assign bus3.align  = bus.align;
`endif

  always #5 base_clock = ~base_clock;

  int total = 0;
  int bad   = 0;

  // Behavioural model: each channel counts down the cycles left until its next toggle.
  int m_left [4];
  int m_act  [4];
  int m_pendv[4];
  bit m_pendf[4];
  bit m_clk  [4];
  bit m_tk   [4];

  typedef struct {
    bit       wen;
    bit [1:0] wch;
    bit [7:0] wdiv;
    bit [3:0] en;
    bit [3:0] exp_var;
    bit [3:0] exp_tick;
    bit [3:0] exp_pend;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_left[i] = 3; m_act[i] = 2; m_pendv[i] = 2;
      m_pendf[i] = 0; m_clk[i] = 0; m_tk[i] = 0;
    end
  endtask

  task automatic model_step(input bit wen, input bit [1:0] wch, input bit [7:0] wdiv,
                            input bit [3:0] en, input bit aln);
    for (int i = 0; i < 4; i++) begin
      bit hit;
      hit = wen && (int'(wch) == i);
      m_tk[i] = 0;
      if (aln) begin
        m_act[i] = m_pendv[i]; m_left[i] = m_act[i] + 1;
        m_clk[i] = 0; m_pendf[i] = 0;
        if (hit) begin m_pendv[i] = wdiv; m_pendf[i] = 1; end
      end else if (en[i] && m_left[i] == 1) begin
        m_clk[i] = !m_clk[i];
        m_tk[i] = m_clk[i];
        m_act[i] = hit ? int'(wdiv) : m_pendv[i];
        m_pendv[i] = m_act[i];
        m_pendf[i] = 0;
        m_left[i] = m_act[i] + 1;
      end else begin
        if (en[i]) m_left[i]--;
        if (hit) begin m_pendv[i] = wdiv; m_pendf[i] = 1; end
      end
    end
  endtask

  function automatic logic [3:0] mvec(input int sel);
    logic [3:0] v;
    for (int i = 0; i < 4; i++)
      v[i] = (sel == 0) ? m_clk[i] : (sel == 1) ? m_tk[i] : m_pendf[i];
    return v;
  endfunction

  // One base cycle: drive inputs, advance model on the edge, compare 1 time unit later.
  task automatic cycle(input bit wen, input bit [1:0] wch, input bit [7:0] wdiv,
                       input bit [3:0] en, input bit aln);
    bus.wr_en = wen; bus.wr_ch = wch; bus.wr_div = wdiv; bus.ch_en = en;
`ifdef PHASE_ALIGN_EN
    bus.align = aln;
`endif
    @(posedge base_clock);
    model_step(wen, wch, wdiv, en, aln);
    #1;
    bus.wr_en = 1'b0;
`ifdef PHASE_ALIGN_EN
    bus.align = 1'b0;
`endif
    check("model_var_clock", bus.var_clock, mvec(0));
    check("model_tick",      bus.tick,      mvec(1));
    check("model_pend",      bus.pend,      mvec(2));
  endtask

  vec_t tbl[9];

  initial begin
    logic [3:0] frozen;
    int guard;
    bus.wr_en = 0; bus.wr_ch = 0; bus.wr_div = 0; bus.ch_en = 4'hF;
`ifdef PHASE_ALIGN_EN
    bus.align = 0;
`endif
    // Start-up pattern: ch2 gets D=5 while cnt=1; others keep the default D=2.
    tbl[0] = '{0, 2'd0, 8'd0, 4'hF, 4'h0, 4'h0, 4'h0};
    tbl[1] = '{1, 2'd2, 8'd5, 4'hF, 4'h0, 4'h0, 4'h4};
    tbl[2] = '{0, 2'd0, 8'd0, 4'hF, 4'hF, 4'hF, 4'h0};
    tbl[3] = '{0, 2'd0, 8'd0, 4'hF, 4'hF, 4'h0, 4'h0};
    tbl[4] = '{0, 2'd0, 8'd0, 4'hF, 4'hF, 4'h0, 4'h0};
    tbl[5] = '{0, 2'd0, 8'd0, 4'hF, 4'h4, 4'h0, 4'h0};
    tbl[6] = '{0, 2'd0, 8'd0, 4'hF, 4'h4, 4'h0, 4'h0};
    tbl[7] = '{0, 2'd0, 8'd0, 4'hF, 4'h4, 4'h0, 4'h0};
    tbl[8] = '{0, 2'd0, 8'd0, 4'hF, 4'hB, 4'hB, 4'h0};

    repeat (3) @(posedge base_clock);
    #1;
    check("reset_var_clock", bus.var_clock, 4'h0);
    check("reset_tick",      bus.tick,      4'h0);
    check("reset_pend",      bus.pend,      4'h0);
    rst_n = 1'b1;
    model_reset();

    for (int k = 0; k < 9; k++) begin
      cycle(tbl[k].wen, tbl[k].wch, tbl[k].wdiv, tbl[k].en, 1'b0);
      check($sformatf("tbl%0d_var", k),  bus.var_clock, tbl[k].exp_var);
      check($sformatf("tbl%0d_tick", k), bus.tick,      tbl[k].exp_tick);
      check($sformatf("tbl%0d_pend", k), bus.pend,      tbl[k].exp_pend);
    end

    // ch1 to D=0: toggles every cycle once its pending boundary passes.
    cycle(1, 2'd1, 8'd0, 4'hF, 0);
    repeat (20) cycle(0, 0, 0, 4'hF, 0);

    // Write ch3 exactly in its boundary cycle: adopted immediately, pend never set.
    guard = 0;
    while (m_left[3] != 1 && guard < 300) begin
      cycle(0, 0, 0, 4'hF, 0);
      guard++;
    end
    check("ch3_boundary_found", (guard < 300), 1);
    cycle(1, 2'd3, 8'd4, 4'hF, 0);
    check("ch3_boundary_write_pend", bus.pend[3], 1'b0);
    repeat (12) cycle(0, 0, 0, 4'hF, 0);

    // Freeze ch0 for 10 cycles.
    frozen = bus.var_clock;
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 0, 4'hE, 0);
      check("freeze_var0",  bus.var_clock[0], frozen[0]);
      check("freeze_tick0", bus.tick[0],      1'b0);
    end
    repeat (8) cycle(0, 0, 0, 4'hF, 0);

    // Asynchronous reset in mid-period.
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_var",  bus.var_clock, 4'h0);
    check("async_rst_tick", bus.tick,      4'h0);
    check("async_rst_pend", bus.pend,      4'h0);
    @(posedge base_clock);
    #1 rst_n = 1'b1;
    model_reset();
    cycle(1, 2'd3, 8'd7, 4'hF, 0);
    check("wr_ch3_pend_nch4", bus.pend,  4'h8);
    check("wr_ch3_pend_nch3", bus3.pend, 3'h0);
    cycle(0, 0, 0, 4'hF, 0);
    cycle(0, 0, 0, 4'hF, 0);
    check("first_rise_cycle3", bus.var_clock, 4'hF);
    check("nch3_var_match", bus3.var_clock, bus.var_clock[2:0]);

`ifdef PHASE_ALIGN_EN
    repeat (4) cycle(0, 0, 0, 4'hF, 0);
    cycle(1, 2'd0, 8'd3, 4'hF, 1);
    check("align_var", bus.var_clock, 4'h0);
    check("align_pend", bus.pend, 4'h1);
    repeat (10) cycle(0, 0, 0, 4'hF, 0);
`endif

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      bit wen;
      bit [3:0] en;
      wen = ($urandom_range(0, 3) == 0);
      en  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
`ifdef PHASE_ALIGN_EN
      cycle(wen, 2'($urandom), 8'($urandom_range(0, 6)), en, ($urandom_range(0, 49) == 0));
`else
      cycle(wen, 2'($urandom), 8'($urandom_range(0, 6)), en, 1'b0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
